// File: rtl/seg_display_scanner.sv
// Time-multiplexes three pages of CPU/memory results onto an 8-digit active-low 7-segment display.
// Each frame scans a shadow copy of the page value, so the digits stay coherent while they are shown.
module seg_display_scanner #(
    parameter int SCAN_DIV    = 100000,
    parameter int PAGE_FRAMES = 250
) (
    input  logic        clk_in,
    input  logic        reset,
    input  logic        enable,
    input  logic        hold,
    input  logic        page_next,
    input  logic [15:0] result_f1,
    input  logic [15:0] result_f2,
    input  logic [15:0] result_f3,
    input  logic [15:0] instruction,
    input  logic [7:0]  i_addr,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel,
    output logic [1:0]  page_o
);

    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int FRAME_W = $clog2(PAGE_FRAMES + 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  SCAN_ONE   = SCAN_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(PAGE_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0:    code = 8'hC0;
            4'h1:    code = 8'hF9;
            4'h2:    code = 8'hA4;
            4'h3:    code = 8'hB0;
            4'h4:    code = 8'h99;
            4'h5:    code = 8'h92;
            4'h6:    code = 8'h82;
            4'h7:    code = 8'hF8;
            4'h8:    code = 8'h80;
            4'h9:    code = 8'h90;
            4'hA:    code = 8'h88;
            4'hB:    code = 8'h83;
            4'hC:    code = 8'hC6;
            4'hD:    code = 8'hA1;
            4'hE:    code = 8'h86;
            4'hF:    code = 8'h8E;
            default: code = 8'hFF;
        endcase
        return code;
    endfunction

    function automatic logic [31:0] page_value(input logic [1:0] pg,
                                               input logic [15:0] f1, input logic [15:0] f2,
                                               input logic [15:0] f3, input logic [15:0] ins,
                                               input logic [7:0] addr);
        logic [31:0] val;
        case (pg)
            2'd0:    val = {f1, f2};
            2'd1:    val = {f3, ins};
            2'd2:    val = {24'h00_0000, addr};
            default: val = 32'h0000_0000;
        endcase
        return val;
    endfunction

    logic [SCAN_W-1:0]  scan_cnt_r,  scan_cnt_s;
    logic [2:0]         digit_r,     digit_s;
    logic [FRAME_W-1:0] frame_cnt_r, frame_cnt_s;
    logic [1:0]         page_r,      page_s,  page_inc_s;
    logic [31:0]        shadow_r,    shadow_s;
    logic               terminal_s,  frame_end_s;
    logic [7:0]         sel_s,       seg_s;
    logic [3:0]         nib_s;
    logic [7:0]         o_seg_r,     o_sel_r;
    logic [1:0]         page_o_r;

    // Next-state scan/page sequencing; page_next pre-empts any auto-advance in the same cycle
    always_comb begin
        scan_cnt_s  = scan_cnt_r;
        digit_s     = digit_r;
        frame_cnt_s = frame_cnt_r;
        page_s      = page_r;
        shadow_s    = shadow_r;
        page_inc_s  = (page_r == 2'd2) ? 2'd0 : page_r + 2'd1;
        terminal_s  = (scan_cnt_r == SCAN_LAST);
        frame_end_s = terminal_s && (digit_r == 3'd7);
        if (!enable) begin
            scan_cnt_s = scan_cnt_r;
        end else if (page_next) begin
            scan_cnt_s  = '0;
            digit_s     = 3'd0;
            frame_cnt_s = '0;
            page_s      = page_inc_s;
            shadow_s    = page_value(page_inc_s, result_f1, result_f2, result_f3, instruction, i_addr);
        end else begin
            scan_cnt_s = terminal_s ? '0 : scan_cnt_r + SCAN_ONE;
            digit_s    = terminal_s ? digit_r + 3'd1 : digit_r;
            if (frame_end_s) begin
                if (hold) begin
                    frame_cnt_s = '0;
                end else if (frame_cnt_r == FRAME_LAST) begin
                    frame_cnt_s = '0;
                    page_s      = page_inc_s;
                end else begin
                    frame_cnt_s = frame_cnt_r + FRAME_ONE;
                end
                // Load the page that is current from the next cycle on, so digit 0 is already fresh
                shadow_s = page_value(page_s, result_f1, result_f2, result_f3, instruction, i_addr);
            end else begin
                shadow_s = shadow_r;
            end
        end
    end

    // Digit decode for the currently scanned digit of the shadow value
    always_comb begin
        nib_s = shadow_r[{digit_r, 2'b00} +: 4];
        sel_s = ~(8'h01 << digit_r);
        if ((page_r == 2'd2) && (digit_r >= 3'd2)) begin
            seg_s = 8'hFF;
        end else if ((digit_r == 3'd4) && (page_r != 2'd2)) begin
            seg_s = hex_to_seg(nib_s) & 8'h7F;
        end else begin
            seg_s = hex_to_seg(nib_s);
        end
        if (!enable) begin
            sel_s = 8'hFF;
            seg_s = 8'hFF;
        end else begin
            sel_s = sel_s;
        end
    end

    // Scanner state and registered display outputs
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            scan_cnt_r  <= '0;
            digit_r     <= 3'd0;
            frame_cnt_r <= '0;
            page_r      <= 2'd0;
            shadow_r    <= 32'h0000_0000;
            o_sel_r     <= 8'hFF;
            o_seg_r     <= 8'hFF;
            page_o_r    <= 2'd0;
        end else begin
            scan_cnt_r  <= scan_cnt_s;
            digit_r     <= digit_s;
            frame_cnt_r <= frame_cnt_s;
            page_r      <= page_s;
            shadow_r    <= shadow_s;
            o_sel_r     <= sel_s;
            o_seg_r     <= seg_s;
            page_o_r    <= page_r;
        end
    end

    assign o_sel  = o_sel_r;
    assign o_seg  = o_seg_r;
    assign page_o = page_o_r;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed and randomized bench for seg_display_scanner against a frame-position reference model.
module tb_seg_display_scanner;

    localparam int SD = 4;
    localparam int PF = 2;
    localparam int FRAME_LEN = 8 * SD;

    logic        clk_in = 1'b0;
    logic        reset = 1'b0, enable = 1'b0, hold = 1'b0, page_next = 1'b0;
    logic [15:0] result_f1 = 16'h0, result_f2 = 16'h0, result_f3 = 16'h0, instruction = 16'h0;
    logic [7:0]  i_addr = 8'h0;
    logic [7:0]  o_seg, o_sel;
    logic [1:0]  page_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position within frame, frames shown on this page, page, latched value
    int          m_pos = 0, m_frames = 0, m_page = 0;
    logic [31:0] m_shadow = 32'h0;
    logic [7:0]  seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_display_scanner #(.SCAN_DIV(SD), .PAGE_FRAMES(PF)) dut (
        .clk_in(clk_in), .reset(reset), .enable(enable), .hold(hold), .page_next(page_next),
        .result_f1(result_f1), .result_f2(result_f2), .result_f3(result_f3),
        .instruction(instruction), .i_addr(i_addr),
        .o_seg(o_seg), .o_sel(o_sel), .page_o(page_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] page_val(input int p);
        if (p == 0)      return {result_f1, result_f2};
        else if (p == 1) return {result_f3, instruction};
        else             return {24'h0, i_addr};
    endfunction

    // One clock: predict outputs from the pre-edge model state, advance the model, compare
    task automatic step();
        logic [7:0] e_sel, e_seg, e_page;
        int d;
        if (!reset) begin
            e_sel = 8'hFF; e_seg = 8'hFF; e_page = 8'h00;
        end else begin
            e_page = 8'(m_page);
            if (!enable) begin
                e_sel = 8'hFF; e_seg = 8'hFF;
            end else begin
                d = m_pos / SD;
                e_sel = ~(8'h01 << d);
                if (m_page == 2 && d >= 2) e_seg = 8'hFF;
                else begin
                    e_seg = seg_tbl[m_shadow[4*d +: 4]];
                    if (d == 4) e_seg[7] = 1'b0;
                end
            end
        end
        if (!reset) begin
            m_pos = 0; m_frames = 0; m_page = 0; m_shadow = 32'h0;
        end else if (enable) begin
            if (page_next) begin
                m_page = (m_page + 1) % 3; m_pos = 0; m_frames = 0; m_shadow = page_val(m_page);
            end else if (m_pos == FRAME_LEN - 1) begin
                m_pos = 0;
                if (hold) m_frames = 0;
                else if (m_frames == PF - 1) begin m_frames = 0; m_page = (m_page + 1) % 3; end
                else m_frames++;
                m_shadow = page_val(m_page);
            end else begin
                m_pos++;
            end
        end
        @(posedge clk_in);
        #1;
        check_value("sel", 32'(o_sel), 32'(e_sel));
        check_value("seg", 32'(o_seg), 32'(e_seg));
        check_value("page", 32'(page_o), 32'(e_page));
    endtask

    initial begin
        int saved_page;
        // Reset with arbitrary inputs
        enable = 1'b1; page_next = 1'b1; hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_value("rst_sel", 32'(o_sel), 32'hFF);
        end
        reset = 1'b1; page_next = 1'b0; hold = 1'b0;
        result_f1 = 16'h1234; result_f2 = 16'hABCD; result_f3 = 16'h00F0;
        instruction = 16'h7E05; i_addr = 8'h3C;
        // Auto-advance through pages 0 -> 1 -> 2 -> 0
        for (int i = 0; i < 200; i++) begin
            step();
            case (i)
                0:   begin check_value("f0_d0", 32'(o_seg), 32'hC0); check_value("f0_sel", 32'(o_sel), 32'hFE); end
                16:  check_value("f0_d4", 32'(o_seg), 32'h40);
                32:  check_value("p0_d0", 32'(o_seg), 32'hA1);
                48:  begin check_value("p0_d4", 32'(o_seg), 32'h19); check_value("p0_s4", 32'(o_sel), 32'hEF); end
                60:  begin check_value("p0_d7", 32'(o_seg), 32'hF9); check_value("p0_s7", 32'(o_sel), 32'h7F); end
                64:  begin check_value("p1_d0", 32'(o_seg), 32'h92); check_value("p1_pg", 32'(page_o), 32'd1); end
                76:  check_value("p1_d3", 32'(o_seg), 32'hF8);
                128: begin check_value("p2_d0", 32'(o_seg), 32'hC6); check_value("p2_pg", 32'(page_o), 32'd2); end
                132: begin check_value("p2_d1", 32'(o_seg), 32'hB0); check_value("p2_s1", 32'(o_sel), 32'hFD); end
                148: begin check_value("p2_d5", 32'(o_seg), 32'hFF); check_value("p2_s5", 32'(o_sel), 32'hDF); end
                192: check_value("wrap_pg", 32'(page_o), 32'd0);
                default: ;
            endcase
        end
        // Freeze during digit 3, with an ignored page_next
        for (int k = 0; k < 64 && m_pos != 13; k++) step();
        check_value("wait_d3", 32'(m_pos), 32'd13);
        enable = 1'b0;
        for (int k = 0; k < 10; k++) begin
            page_next = (k == 4);
            step();
            check_value("frz_sel", 32'(o_sel), 32'hFF);
        end
        page_next = 1'b0; enable = 1'b1;
        for (int k = 0; k < 40; k++) step();
        // Hold for 10 frames, then page_next on the exact auto-advance edge
        saved_page = m_page; hold = 1'b1;
        for (int k = 0; k < 10 * FRAME_LEN; k++) step();
        check_value("hold_pg", 32'(page_o), 32'(saved_page));
        hold = 1'b0;
        for (int k = 0; k < 200 && !(m_pos == FRAME_LEN - 1 && m_frames == PF - 1); k++) step();
        check_value("wait_eof", 32'(m_pos == FRAME_LEN - 1 && m_frames == PF - 1), 32'd1);
        saved_page = m_page;
        page_next = 1'b1; step(); page_next = 1'b0;
        step();
        check_value("pn_pg", 32'(page_o), 32'((saved_page + 1) % 3));
        check_value("pn_sel", 32'(o_sel), 32'hFE);
        // Randomized traffic: data changes mid-frame, pauses, manual advances, rare resets
        for (int k = 0; k < 3000; k++) begin
            enable    = ($urandom_range(0, 19) != 0);
            page_next = ($urandom_range(0, 59) == 0);
            reset     = ($urandom_range(0, 499) != 0);
            if (m_pos == 0) hold = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) result_f1 = 16'($urandom);
            if ($urandom_range(0, 7) == 0) result_f2 = 16'($urandom);
            if ($urandom_range(0, 7) == 0) result_f3 = 16'($urandom);
            if ($urandom_range(0, 7) == 0) instruction = 16'($urandom);
            if ($urandom_range(0, 7) == 0) i_addr = 8'($urandom);
            step();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
